// File: rtl/wptr_full_ctrl.sv
// Write-domain half of an async FIFO: write pointer (binary + Gray), read-pointer
// synchroniser, and full / almost-full / level / sticky-overflow status.
module wptr_full_ctrl #(
    parameter int ADDRSIZE     = 8,
    parameter int AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // XOR-prefix from the MSB down.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wq1_q, wq1_d;
    logic [PW-1:0] wq2_q, wq2_d;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wovf_q, wovf_d;

    logic          wclken_c;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_next;
    logic [PW-1:0] rptr_full_pat;

    always_comb begin
        wclken_c      = winc & ~wfull_q;
        wbin_d        = wbin_q + {{(PW-1){1'b0}}, wclken_c};
        wptr_d        = bin2gray(wbin_d);
        wq1_d         = rptr;
        wq2_d         = wq1_q;
        rbin_s        = gray2bin(wq2_q);
        level_next    = wbin_d - rbin_s;
        // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
        rptr_full_pat = {~wq2_q[ADDRSIZE:ADDRSIZE-1], wq2_q[ADDRSIZE-2:0]};
        wfull_d       = (wptr_d == rptr_full_pat);
        wafull_d      = (level_next >= AFULL_L);
        wlevel_d      = level_next;
        wovf_d        = wovf_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wq1_q    <= '0;
            wq2_q    <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wq1_q    <= wq1_d;
            wq2_q    <= wq2_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wclken       = wclken_c;
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign wovf         = wovf_q;

endmodule
